reg_bank: RTL and testbench

Parametrised successor to the single temporary register: a bank of DEPTH general-purpose registers, each WIDTH bits, sharing one data bus. The bank adds in-place increment, decrement and clear, plus zero and carry flags, so the control sequencer can use any register as a loop counter without an ALU round trip. It attaches to the shared tri-state bus like every other bus-resident register.

---
 rtl/reg_bank_pkg.sv | 18 +
 rtl/reg_bank_cell.sv | 54 +++++
 rtl/reg_bank.sv | 101 ++++++++++
 tb/tb_reg_bank.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// rtl/reg_bank_pkg.sv - shared op encoding for the register bank
package reg_bank_pkg;

  typedef enum logic [2:0] {
    NOP    = 3'd0,
    LOAD   = 3'd1,
    ENABLE = 3'd2,
    INC    = 3'd3,
    DEC    = 3'd4,
    CLEAR  = 3'd5
  } reg_bank_op_e;

  // Ops that modify a register and therefore update the flags.
  function automatic logic is_write_op(reg_bank_op_e op);
    return (op == LOAD) || (op == INC) || (op == DEC) || (op == CLEAR);
  endfunction

endpackage

// File: rtl/reg_bank_cell.sv
// rtl/reg_bank_cell.sv - one bank register with in-place load/inc/dec/clear
module reg_bank_cell
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  reg_bank_op_e     op_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] value_o,
  output logic [WIDTH-1:0] next_o,
  output logic             carry_o
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;
  logic             carry_d;

  // Next value and wrap/borrow for this cycle's op; unselected cells see NOP.
  always_comb begin
    value_d = value_q;
    carry_d = 1'b0;
    case (op_i)
      LOAD:  value_d = data_i;
      INC:   {carry_d, value_d} = {1'b0, value_q} + {1'b0, ONE};
      DEC: begin
        value_d = value_q - ONE;
        carry_d = (value_q == '0);
      end
      CLEAR: value_d = '0;
      default: begin
        value_d = value_q;
        carry_d = 1'b0;
      end
    endcase
  end

  // Register storage; cleared asynchronously.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;
  assign next_o  = value_d;
  assign carry_o = carry_d;

endmodule

// File: rtl/reg_bank.sv
// rtl/reg_bank.sv - bus-resident bank of counter-capable registers with zero/carry flags
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int SEL_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0] bus_out,
  input  logic [SEL_W-1:0] sel,
  input  reg_bank_op_e     op,
  output logic             zero,
  output logic             carry
);

  reg_bank_op_e     cell_op    [DEPTH];
  logic [WIDTH-1:0] cell_value [DEPTH];
  logic [WIDTH-1:0] cell_next  [DEPTH];
  logic [DEPTH-1:0] cell_carry;

  logic             sel_valid;
  logic [WIDTH-1:0] rd_value;
  logic [WIDTH-1:0] sel_next;
  logic             sel_carry;

  logic             zero_q;
  logic             zero_d;
  logic             carry_q;
  logic             carry_d;
  logic             bus_oe;

  // Route the op only to the selected cell; an out-of-range sel reaches none.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      cell_op[i] = (sel == SEL_W'(i)) ? op : NOP;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_cell
    reg_bank_cell #(
      .WIDTH (WIDTH)
    ) u_cell (
      .clock   (clock),
      .reset   (reset),
      .op_i    (cell_op[g]),
      .data_i  (bus_in),
      .value_o (cell_value[g]),
      .next_o  (cell_next[g]),
      .carry_o (cell_carry[g])
    );
  end

  // Pick the selected cell's current value, next value and carry; zeros when out of range.
  always_comb begin
    sel_valid = 1'b0;
    rd_value  = '0;
    sel_next  = '0;
    sel_carry = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_valid = 1'b1;
        rd_value  = cell_value[i];
        sel_next  = cell_next[i];
        sel_carry = cell_carry[i];
      end
    end
  end

  // Flags follow write-type ops on a real register; LOAD leaves carry alone.
  always_comb begin
    zero_d  = zero_q;
    carry_d = carry_q;
    if (sel_valid && is_write_op(op)) begin
      zero_d = (sel_next == '0);
      if (op != LOAD) begin
        carry_d = sel_carry;
      end
    end
  end

  // Flag registers; cleared asynchronously.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  // Bus is released during reset and in every op but ENABLE.
  assign bus_oe  = reset && (op == ENABLE);
  assign bus_out = bus_oe ? rd_value : {WIDTH{1'bz}};
  assign zero    = zero_q;
  assign carry   = carry_q;

endmodule

// File: tb/tb_reg_bank.sv
// tb/tb_reg_bank.sv - randomized model-checked bench for reg_bank (DEPTH 4 and 3)
module tb_reg_bank;
  import reg_bank_pkg::*;

  logic         clock  = 1'b0;
  logic         reset  = 1'b0;
  logic [7:0]   bus_in = 8'h00;
  logic [1:0]   sel    = 2'd0;
  reg_bank_op_e op     = ENABLE;

  wire  [7:0]   bus4;
  wire  [7:0]   bus3;
  logic         zero4, carry4, zero3, carry3;

  int tests = 0;
  int fails = 0;

  int mreg [2][4] = '{default: 0};
  bit mz [2] = '{0, 0};
  bit mc [2] = '{0, 0};
  int mdepth [2] = '{4, 3};
  int mr;

  always #5 clock = ~clock;

  reg_bank #(.WIDTH(8), .DEPTH(4)) u4 (
    .clock(clock), .reset(reset), .bus_in(bus_in), .bus_out(bus4),
    .sel(sel), .op(op), .zero(zero4), .carry(carry4)
  );

  reg_bank #(.WIDTH(8), .DEPTH(3)) u3 (
    .clock(clock), .reset(reset), .bus_in(bus_in), .bus_out(bus3),
    .sel(sel), .op(op), .zero(zero3), .carry(carry3)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: registers as plain integers, modular arithmetic from the op rules.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < 4; i++) mreg[d][i] = 0;
        mz[d] = 0;
        mc[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (int'(sel) < mdepth[d]) begin
          mr = mreg[d][sel];
          case (op)
            LOAD: begin
              mr = int'(bus_in);
              mz[d] = (mr == 0);
            end
            INC: begin
              mc[d] = (mr == 255);
              mr = (mr + 1) % 256;
              mz[d] = (mr == 0);
            end
            DEC: begin
              mc[d] = (mr == 0);
              mr = (mr + 255) % 256;
              mz[d] = (mr == 0);
            end
            CLEAR: begin
              mr = 0;
              mz[d] = 1;
              mc[d] = 0;
            end
            default: ;
          endcase
          mreg[d][sel] = mr;
        end
      end
    end
  end

  // Compare both instances against the model every cycle, mid-cycle.
  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      logic       exp_oe;
      logic [7:0] exp_val;
      logic       got_oe;
      logic [7:0] got_val;
      logic       got_z, got_c;
      exp_oe  = reset && (op == ENABLE);
      exp_val = (int'(sel) < mdepth[d]) ? 8'(mreg[d][sel]) : 8'h00;
      got_oe  = (d == 0) ? u4.bus_oe : u3.bus_oe;
      got_val = (d == 0) ? bus4 : bus3;
      got_z   = (d == 0) ? zero4 : zero3;
      got_c   = (d == 0) ? carry4 : carry3;
      chk($sformatf("oe_d%0d", d), 32'(got_oe), 32'(exp_oe));
      if (exp_oe) chk($sformatf("bus_d%0d_sel%0d", d, sel), 32'(got_val), 32'(exp_val));
      chk($sformatf("zero_d%0d", d), 32'(got_z), 32'(mz[d]));
      chk($sformatf("carry_d%0d", d), 32'(got_c), 32'(mc[d]));
    end
  end

  task automatic do_op(input reg_bank_op_e o, input int s, input logic [7:0] d);
    @(posedge clock);
    #1;
    op     = o;
    sel    = s[1:0];
    bus_in = d;
    #1;
  endtask

  initial begin
    reset = 1'b0;
    op    = ENABLE;
    sel   = 2'd0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_oe", 32'(u4.bus_oe), 32'd0);
    chk("rst_zero", 32'(zero4), 32'd0);
    chk("rst_carry", 32'(carry4), 32'd0);
    @(posedge clock);
    #1 reset = 1'b1;

    for (int s = 0; s < 4; s++) begin
      do_op(ENABLE, s, 8'h00);
      chk($sformatf("rd_init%0d", s), 32'(bus4), 32'h00);
    end
    chk("init_zero", 32'(zero4), 32'd0);
    chk("init_carry", 32'(carry4), 32'd0);

    do_op(LOAD, 2, 8'hA5);
    do_op(ENABLE, 2, 8'h00);
    chk("load_a5", 32'(bus4), 32'hA5);
    chk("load_a5_zero", 32'(zero4), 32'd0);
    do_op(ENABLE, 1, 8'h00);
    chk("rd_sel1", 32'(bus4), 32'h00);

    do_op(LOAD, 1, 8'hFF);
    do_op(INC, 1, 8'h00);
    do_op(ENABLE, 1, 8'h00);
    chk("inc_wrap", 32'(bus4), 32'h00);
    chk("inc_wrap_carry", 32'(carry4), 32'd1);
    chk("inc_wrap_zero", 32'(zero4), 32'd1);
    do_op(INC, 1, 8'h00);
    do_op(ENABLE, 1, 8'h00);
    chk("inc_1", 32'(bus4), 32'h01);
    chk("inc_1_carry", 32'(carry4), 32'd0);
    chk("inc_1_zero", 32'(zero4), 32'd0);

    do_op(CLEAR, 3, 8'h00);
    do_op(DEC, 3, 8'h00);
    do_op(ENABLE, 3, 8'h00);
    chk("dec_borrow", 32'(bus4), 32'hFF);
    chk("dec_borrow_carry", 32'(carry4), 32'd1);
    chk("dec_borrow_zero", 32'(zero4), 32'd0);
    do_op(LOAD, 3, 8'h01);
    do_op(DEC, 3, 8'h00);
    do_op(ENABLE, 3, 8'h00);
    chk("dec_to0", 32'(bus4), 32'h00);
    chk("dec_to0_zero", 32'(zero4), 32'd1);
    chk("dec_to0_carry", 32'(carry4), 32'd0);

    for (int k = 0; k < 3; k++) begin
      do_op(NOP, 2, 8'h00);
      chk("nop_release", 32'(u4.bus_oe), 32'd0);
      do_op(ENABLE, 2, 8'h00);
      chk("enable_nolag", 32'(bus4), 32'hA5);
    end

    do_op(CLEAR, 0, 8'h00);
    do_op(LOAD, 3, 8'h55);
    do_op(ENABLE, 3, 8'h00);
    chk("d3_oob_oe", 32'(u3.bus_oe), 32'd1);
    chk("d3_oob_bus", 32'(bus3), 32'h00);
    chk("d3_oob_zero", 32'(zero3), 32'd1);
    chk("d3_oob_carry", 32'(carry3), 32'd0);
    chk("d4_sel3_load", 32'(bus4), 32'h55);

    do_op(LOAD, 0, 8'h10);
    do_op(INC, 0, 8'h00);
    @(posedge clock);
    #1;
    reset = 1'b0;
    op    = ENABLE;
    sel   = 2'd0;
    #1;
    chk("midrst_oe", 32'(u4.bus_oe), 32'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    for (int s = 0; s < 4; s++) begin
      do_op(ENABLE, s, 8'h00);
      chk($sformatf("midrst_rd%0d", s), 32'(bus4), 32'h00);
    end

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
      end else begin
        logic [7:0] d;
        case ($urandom_range(0, 3))
          0: d = 8'h00;
          1: d = 8'hFF;
          2: d = 8'h01;
          default: d = 8'($urandom);
        endcase
        do_op(reg_bank_op_e'($urandom_range(0, 5)), int'($urandom_range(0, 3)), d);
      end
    end

    @(posedge clock);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
